// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache, one word per frame.
// A miss writes back a dirty victim first, then fills. halt flushes every dirty
// frame in index order and parks the cache with flushed=1 until reset.
module dcache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 30 - IDX;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WB     = 3'd1;
    localparam logic [2:0] FILL   = 3'd2;
    localparam logic [2:0] FLUSH  = 3'd3;
    localparam logic [2:0] HALTED = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [IDX-1:0]  fidx_q, fidx_d;
    logic [SETS-1:0] valid_q, dirty_q;
    logic [TAGW-1:0] tag_q  [SETS];
    logic [31:0]     data_q [SETS];

    logic [IDX-1:0]  idx, clean_idx;
    logic [TAGW-1:0] tag;
    logic            hit, victim_dirty, flush_dirty;
    logic            store_en, fill_en, clean_en;
    logic            unused_addr_bits;

    // Request decode; the low two address bits are a byte offset and carry no meaning here.
    assign idx              = dmemaddr[IDX+1:2];
    assign tag              = dmemaddr[31:IDX+2];
    assign hit              = valid_q[idx] && (tag_q[idx] == tag);
    assign victim_dirty     = valid_q[idx] && dirty_q[idx];
    assign flush_dirty      = valid_q[fidx_q] && dirty_q[fidx_q];
    assign unused_addr_bits = ^dmemaddr[1:0];

    // Next state, datapath response and memory-side request, all from the current state.
    always_comb begin
        state_d   = state_q;
        fidx_d    = fidx_q;
        dhit      = 1'b0;
        dmemload  = '0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        daddr     = '0;
        dstore    = '0;
        store_en  = 1'b0;
        fill_en   = 1'b0;
        clean_en  = 1'b0;
        clean_idx = idx;
        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLUSH;
                    fidx_d  = '0;
                end else if (dmemWEN) begin
                    // Writes win over simultaneous reads; a clean or empty victim is simply overwritten.
                    if (hit || !victim_dirty) begin
                        dhit     = 1'b1;
                        dmemload = data_q[idx];
                        store_en = 1'b1;
                    end else begin
                        state_d = WB;
                    end
                end else if (dmemREN) begin
                    if (hit) begin
                        dhit     = 1'b1;
                        dmemload = data_q[idx];
                    end else if (victim_dirty) begin
                        state_d = WB;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = {tag_q[idx], idx, 2'b00};
                dstore = data_q[idx];
                if (!dwait) begin
                    clean_en = 1'b1;
                    // A pending write re-enters IDLE and installs through the clean path.
                    state_d  = (!dmemWEN && dmemREN) ? FILL : IDLE;
                end
            end
            FILL: begin
                dREN  = 1'b1;
                daddr = {dmemaddr[31:2], 2'b00};
                if (!dwait) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                clean_idx = fidx_q;
                if (flush_dirty) begin
                    dWEN   = 1'b1;
                    daddr  = {tag_q[fidx_q], fidx_q, 2'b00};
                    dstore = data_q[fidx_q];
                end
                // Clean frames step in one cycle; dirty ones wait for their write to land.
                if (!flush_dirty || !dwait) begin
                    clean_en = flush_dirty;
                    if (&fidx_q) begin
                        state_d = HALTED;
                    end else begin
                        fidx_d = fidx_q + IDX'(1);
                    end
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase
        flushed = (state_q == HALTED);
    end

    // Controller state and flush scan index.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            fidx_q  <= fidx_d;
        end
    end

    // Frame status bits; reset invalidates everything and drops dirty data.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (store_en) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b1;
            end
            if (fill_en) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
            if (clean_en) begin
                dirty_q[clean_idx] <= 1'b0;
            end
        end
    end

    // Tag and data storage; contents are qualified by valid so they need no reset.
    always_ff @(posedge CLK) begin
        if (store_en) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= dmemstore;
        end
        if (fill_en) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= dload;
        end
    end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: scoreboard bench for dcache (SETS=16). Expected load data and expected
// memory transfers are queued at issue time from a word-level model of the cache;
// a monitor checks datapath responses and a memory responder checks every transfer.
`timescale 1ns/1ps
module tb_dcache;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        halt = 1'b0;
    logic        dmemREN = 1'b0;
    logic        dmemWEN = 1'b0;
    logic [31:0] dmemaddr = '0;
    logic [31:0] dmemstore = '0;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;
    logic        dwait = 1'b1;
    logic [31:0] dload = '0;

    dcache #(.SETS(16)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload)
    );

    always #5 CLK = ~CLK;

    typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } xfer_t;
    typedef struct { bit rd; logic [31:0] data; } resp_t;

    xfer_t       exq[$];
    resp_t       sbq[$];
    int          vectors = 0;
    int          errors = 0;
    int          fixed_lat = -1;
    int          nwr = 0;
    logic [31:0] mem [logic [31:0]];
    bit          mv [16];
    bit          mdty [16];
    logic [31:0] ma [16];
    logic [31:0] mdat [16];

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    // Memory responder: random (or fixed) wait states, stability and traffic checks.
    bit    in_xfer = 1'b0;
    int    wcnt = 0;
    xfer_t cur;
    xfer_t e;
    always @(negedge CLK) begin
        if (!nRST) begin
            in_xfer = 1'b0;
            dwait   = 1'b1;
        end else if (dREN || dWEN) begin
            chk1("ren_wen_exclusive", dREN & dWEN, 1'b0);
            if (!in_xfer) begin
                in_xfer = 1'b1;
                wcnt    = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                cur     = '{dWEN, daddr, dstore};
            end else begin
                chk("req_stable_addr", daddr, cur.addr);
                chk1("req_stable_dir", dWEN, cur.we);
                if (cur.we) chk("req_stable_data", dstore, cur.data);
            end
            dwait = (wcnt != 0);
            if (wcnt == 0) begin
                in_xfer = 1'b0;
                if (dWEN) begin
                    mem[daddr] = dstore;
                    nwr++;
                end else begin
                    dload = rd(daddr);
                end
                if (exq.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_xfer: got we=%b addr=%h data=%h, required no transfer", dWEN, daddr, dstore);
                end else begin
                    e = exq.pop_front();
                    chk1("xfer_dir", dWEN, e.we);
                    chk("xfer_addr", daddr, e.addr);
                    if (e.we) chk("xfer_data", dstore, e.data);
                end
            end else begin
                wcnt--;
            end
        end else begin
            dwait = 1'b1;
        end
    end

    // Response monitor: every dhit consumes one scoreboard entry.
    resp_t r;
    always @(negedge CLK) begin
        if (nRST && dhit) begin
            if (sbq.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_dhit: got dhit=1 at addr %h, required 0", dmemaddr);
            end else begin
                r = sbq.pop_front();
                if (r.rd) chk("load_data", dmemload, r.data);
            end
        end
    end

    // One datapath request: predict with the model, drive, hold until dhit.
    task automatic access(input bit w, input bit rq, input logic [31:0] a, input logic [31:0] d,
                          output int waits, output int rcyc);
        int          i;
        logic [31:0] la;
        bit          hit, zero;
        i    = int'(a[5:2]);
        la   = {a[31:2], 2'b00};
        hit  = mv[i] && (ma[i] == la);
        zero = 1'b0;
        if (w) begin
            if (!hit && mv[i] && mdty[i]) exq.push_back('{1'b1, ma[i], mdat[i]});
            else zero = 1'b1;
            mv[i] = 1'b1; ma[i] = la; mdat[i] = d; mdty[i] = 1'b1;
            sbq.push_back('{1'b0, 32'h0});
        end else begin
            if (hit) begin
                zero = 1'b1;
            end else begin
                if (mv[i] && mdty[i]) exq.push_back('{1'b1, ma[i], mdat[i]});
                exq.push_back('{1'b0, la, 32'h0});
                mv[i] = 1'b1; ma[i] = la; mdat[i] = rd(la); mdty[i] = 1'b0;
            end
            sbq.push_back('{1'b1, mdat[i]});
        end
        dmemWEN = w; dmemREN = rq; dmemaddr = a; dmemstore = d;
        waits = 0;
        rcyc  = 0;
        forever begin
            @(negedge CLK);
            if (dhit) break;
            waits++;
            if (dREN) rcyc++;
            if (waits > 400) begin
                vectors++;
                errors++;
                $display("FAIL dhit_timeout: got no dhit in %0d cycles at addr %h, required completion", waits, a);
                break;
            end
        end
        @(posedge CLK);
        #1;
        dmemWEN = 1'b0;
        dmemREN = 1'b0;
        if (zero) chk("hit_latency", waits, 0);
        else      chk1("miss_stalls", waits > 0, 1'b1);
        chk("traffic_left", exq.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1);
    end

    initial begin
        int          w, t, seen, nwr0, k;
        logic [31:0] a;
        repeat (3) @(posedge CLK);
        #1;
        chk1("rst_dhit", dhit, 1'b0);
        chk1("rst_flushed", flushed, 1'b0);
        chk1("rst_dren", dREN, 1'b0);
        chk1("rst_dwen", dWEN, 1'b0);
        chk("rst_daddr", daddr, 32'h0);
        chk("rst_dstore", dstore, 32'h0);
        chk("rst_dmemload", dmemload, 32'h0);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Read miss, then repeat hit.
        mem[32'h40] = 32'hDEADBEEF;
        fixed_lat   = 3;
        access(1'b0, 1'b1, 32'h40, 32'h0, w, t);
        chk("s1_fill_cycles", t, 4);
        chk("s1_latency", w, 5);
        access(1'b0, 1'b1, 32'h40, 32'h0, w, t);
        chk("s1_rehit_dren", t, 0);
        fixed_lat = -1;

        // Write miss into empty frame, read back, then conflict eviction.
        access(1'b1, 1'b0, 32'h44, 32'h12345678, w, t);
        access(1'b0, 1'b1, 32'h44, 32'h0, w, t);
        access(1'b0, 1'b1, 32'h84, 32'h0, w, t);
        access(1'b0, 1'b1, 32'h84, 32'h0, w, t);

        // Simultaneous read+write is a write; eviction proves the frame went dirty.
        access(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, w, t);
        access(1'b0, 1'b1, 32'h40, 32'h0, w, t);
        access(1'b0, 1'b1, 32'h80, 32'h0, w, t);

        // Random traffic over 64 words (4 tags per frame), random byte offsets.
        for (int n = 0; n < 300; n++) begin
            k = int'($urandom_range(0, 2));
            a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
            access(k != 0, k != 1, a, $urandom, w, t);
        end

        // Reset in the middle of a fill.
        a = 32'h1C;
        for (int n = 0; n < 4; n++) begin
            if (!mv[7] || ma[7] != 32'h1C + 32'(n) * 32'h40) begin
                a = 32'h1C + 32'(n) * 32'h40;
                break;
            end
        end
        if (mv[7] && mdty[7] && ma[7] != a) exq.push_back('{1'b1, ma[7], mdat[7]});
        fixed_lat = 20;
        dmemaddr  = a;
        dmemREN   = 1'b1;
        seen      = 0;
        for (int n = 0; n < 200 && seen < 2; n++) begin
            @(negedge CLK);
            if (dREN) seen++;
        end
        chk("s5_fill_reached", seen, 2);
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk1("s5_dren_async", dREN, 1'b0);
        chk1("s5_dwen_async", dWEN, 1'b0);
        chk("s5_daddr_async", daddr, 32'h0);
        dmemREN = 1'b0;
        exq.delete();
        sbq.delete();
        for (int n = 0; n < 16; n++) begin
            mv[n] = 1'b0;
            mdty[n] = 1'b0;
        end
        repeat (2) @(posedge CLK);
        #1;
        nRST      = 1'b1;
        fixed_lat = -1;
        access(1'b0, 1'b1, a, 32'h0, w, t);
        chk1("s5_misses_again", t > 0, 1'b1);

        // Flush with frames 3 and 9 dirty, frame 5 clean.
        access(1'b1, 1'b0, 32'h0C, 32'hA0A0_0003, w, t);
        access(1'b1, 1'b0, 32'h24, 32'hB0B0_0009, w, t);
        access(1'b0, 1'b1, 32'h54, 32'h0, w, t);
        access(1'b1, 1'b0, 32'h0C, 32'hA0A0_0333, w, t);
        for (int n = 0; n < 16; n++) begin
            if (mv[n] && mdty[n]) exq.push_back('{1'b1, ma[n], mdat[n]});
        end
        nwr0 = nwr;
        halt = 1'b1;
        seen = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge CLK);
            if (flushed) begin
                seen = 1;
                break;
            end
        end
        chk1("s4_flushed", seen != 0, 1'b1);
        chk("s4_write_count", nwr - nwr0, 2);
        chk("s4_traffic_left", exq.size(), 0);
        for (int n = 0; n < 8; n++) begin
            @(posedge CLK);
            #1;
            dmemREN = n[0];
            @(negedge CLK);
            chk1("s4_flushed_held", flushed, 1'b1);
            chk1("s4_no_dhit", dhit, 1'b0);
        end
        dmemREN = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
